// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: data width and the
// handshake FSM state type used by the feeder.
package uart_pkg;

   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN
   } tx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing asynchronous level signals into clk.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Metastability-settling stage followed by the output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of the 8N1 transmitter. Bytes written on wr_en are
// queued and issued one at a time through send_enable/send_data, paced by
// the synchronized transmitter busy flag. Attempts that never see busy
// within ACK_TIMEOUT cycles are abandoned and flagged on tx_err.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned ACK_TIMEOUT = 4096
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     tx_err,
   output logic                     send_enable,
   output logic [DATA_W-1:0]        send_data,
   input  logic                     uart_busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned TW = $clog2(ACK_TIMEOUT) + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [LW-1:0]     count;

   logic              busy_s;
   logic              wr_ok;
   logic              pop;

   tx_state_t         state_q;
   tx_state_t         state_d;
   logic [TW-1:0]     tmo_q;
   logic [TW-1:0]     tmo_d;
   logic              se_d;
   logic [DATA_W-1:0] sd_d;
   logic              err_d;

   sync_2ff #(
      .WIDTH (1)
   ) u_busy_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (uart_busy),
      .q     (busy_s)
   );

   // Status flags come straight from the registered occupancy count.
   assign full  = (count == LW'(DEPTH));
   assign empty = (count == '0);
   assign level = count;
   assign wr_ok = wr_en & ~full;

   // FIFO storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy and the overflow pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= wr_en & full;
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_ok, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   // Handshake state and registered transmitter-facing outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         tmo_q       <= '0;
         send_enable <= 1'b0;
         send_data   <= '0;
         tx_err      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         send_enable <= se_d;
         send_data   <= sd_d;
         tx_err      <= err_d;
      end
   end

   // Next-state, pop decision and output values for the handshake.
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      se_d    = send_enable;
      sd_d    = send_data;
      err_d   = 1'b0;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty && !busy_s) begin
               sd_d    = mem[rd_ptr];
               pop     = 1'b1;
               se_d    = 1'b1;
               tmo_d   = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (busy_s) begin
               se_d    = 1'b0;
               state_d = ST_DRAIN;
            end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
               se_d    = 1'b0;
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (tmo_q != '1) begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_DRAIN: begin
            if (!busy_s) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            se_d    = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: a behavioural model of the FIFO
// and handshake rules, a model transmitter driving uart_busy, a directed
// table for burst/overflow, hand sequences for corner cases and a random run.
module tb_uart_tx_feeder;

   localparam int DEPTH = 16;
   localparam int ATO   = 8;
   localparam int P_IDLE  = 0;
   localparam int P_ISSUE = 1;
   localparam int P_DRAIN = 2;
   localparam int M_NORMAL = 0;
   localparam int M_STALL  = 1;
   localparam int M_DEAD   = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       full, empty, overflow, tx_err, send_enable;
   logic [4:0] level;
   logic [7:0] send_data;
   logic       uart_busy = 1'b0;

   uart_tx_feeder #(
      .DEPTH       (DEPTH),
      .ACK_TIMEOUT (ATO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .full        (full),
      .empty       (empty),
      .level       (level),
      .overflow    (overflow),
      .tx_err      (tx_err),
      .send_enable (send_enable),
      .send_data   (send_data),
      .uart_busy   (uart_busy)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                    name, act, act, exp, exp, $time);
   endtask

   // ---------------- reference model ----------------
   logic [7:0] m_q[$];
   int         m_phase;
   int         m_tmo;
   bit         m_b1, m_b2;
   bit         m_se, m_ovf, m_err;
   logic [7:0] m_sd;

   task automatic model_reset();
      m_q.delete();
      m_phase = P_IDLE; m_tmo = 0;
      m_b1 = 0; m_b2 = 0;
      m_se = 0; m_ovf = 0; m_err = 0; m_sd = '0;
   endtask

   task automatic model_step(input bit w, input logic [7:0] d, input bit ub);
      bit fullm, emptym, bs;
      fullm  = (m_q.size() == DEPTH);
      emptym = (m_q.size() == 0);
      bs     = m_b2;
      m_ovf  = w && fullm;
      m_err  = 0;
      case (m_phase)
         P_IDLE: if (!emptym && !bs) begin
            m_sd = m_q.pop_front(); m_se = 1; m_tmo = 0; m_phase = P_ISSUE;
         end
         P_ISSUE: begin
            if (bs) begin m_se = 0; m_phase = P_DRAIN; end
            else if (m_tmo == ATO - 1) begin m_se = 0; m_err = 1; m_phase = P_IDLE; end
            else m_tmo++;
         end
         default: if (!bs) m_phase = P_IDLE;
      endcase
      if (w && !fullm) m_q.push_back(d);
      m_b2 = m_b1;
      m_b1 = ub;
   endtask

   // ---------------- model transmitter ----------------
   int         u_mode = M_NORMAL;
   int         u_frame = 0;
   int         u_wait = 0;
   int         u_delay = 0;
   int         u_len = 4;
   logic [7:0] rx_q[$];

   task automatic uart_start();
      if (send_enable) begin
         rx_q.push_back(send_data);
         uart_busy = 1'b1;
         u_frame = u_len;
      end
   endtask

   task automatic uart_step();
      case (u_mode)
         M_STALL: uart_busy = 1'b1;
         M_DEAD:  uart_busy = 1'b0;
         default: begin
            if (u_frame > 0) begin
               u_frame--;
               uart_busy = (u_frame != 0);
            end else begin
               uart_busy = 1'b0;
               if (u_wait > 0) begin
                  u_wait--;
                  if (u_wait == 0) uart_start();
               end else if (send_enable) begin
                  if (u_delay == 0) uart_start();
                  else u_wait = u_delay;
               end
            end
         end
      endcase
   endtask

   task automatic compare_all();
      chk("send_enable", int'(send_enable), int'(m_se));
      chk("send_data",   int'(send_data),   int'(m_sd));
      chk("level",       int'(level),       m_q.size());
      chk("empty",       int'(empty),       int'(m_q.size() == 0));
      chk("full",        int'(full),        int'(m_q.size() == DEPTH));
      chk("overflow",    int'(overflow),    int'(m_ovf));
      chk("tx_err",      int'(tx_err),      int'(m_err));
   endtask

   task automatic tick();
      bit w, ub, r;
      logic [7:0] d;
      w = wr_en; d = wr_data; ub = uart_busy; r = rst_n;
      @(posedge clk);
      if (!r) model_reset();
      else    model_step(w, d, ub);
      #1;
      compare_all();
      uart_step();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      wr_en = 1'b0;
      while (!(empty && !send_enable && !uart_busy) && k < 1000) begin
         tick();
         k++;
      end
      chk(name, int'(k < 1000), 1);
      run(4);
   endtask

   typedef struct {
      bit         wr;
      logic [7:0] data;
      int         exp_level;
      bit         exp_full;
      bit         exp_ovf;
   } vec_t;

   vec_t tbl[19];

   initial begin
      int         cnt, last_se, err_at, errs;
      logic [7:0] b;

      for (int i = 0; i < 19; i++) begin
         tbl[i].wr        = (i < 17);
         tbl[i].data      = 8'(i);
         tbl[i].exp_level = (i < 16) ? i + 1 : 16;
         tbl[i].exp_full  = (i >= 15);
         tbl[i].exp_ovf   = (i == 16);
      end

      // ---- reset state ----
      model_reset();
      rst_n = 1'b0;
      run(2);
      rst_n = 1'b1;
      run(2);
      chk("rst_empty", int'(empty), 1);
      chk("rst_level", int'(level), 0);

      // ---- single byte ----
      u_mode = M_NORMAL; u_delay = 0; u_len = 4;
      rx_q.delete();
      wr_en = 1'b1; wr_data = 8'h41;
      tick();
      wr_en = 1'b0;
      chk("single_level_after_write", int'(level), 1);
      chk("single_se_early", int'(send_enable), 0);
      tick();
      chk("single_se_rise", int'(send_enable), 1);
      chk("single_data", int'(send_data), 8'h41);
      cnt = 0;
      while (send_enable && cnt < 20) begin
         tick();
         cnt++;
      end
      chk("single_se_fall_cycles", cnt, 3);
      drain("single_drain");
      chk("single_rx_count", rx_q.size(), 1);
      b = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      chk("single_rx_byte", int'(b), 8'h41);

      // ---- burst + overflow with the transmitter stalled ----
      u_mode = M_STALL;
      rx_q.delete();
      run(3);
      for (int i = 0; i < 19; i++) begin
         wr_en = tbl[i].wr; wr_data = tbl[i].data;
         tick();
         chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].exp_level);
         chk($sformatf("tbl%0d_full", i), int'(full), int'(tbl[i].exp_full));
         chk($sformatf("tbl%0d_overflow", i), int'(overflow), int'(tbl[i].exp_ovf));
      end
      wr_en = 1'b0;
      u_mode = M_NORMAL;
      drain("burst_drain");
      chk("burst_rx_count", rx_q.size(), 16);
      for (int i = 0; i < 16 && i < rx_q.size(); i++)
         chk($sformatf("burst_rx%0d", i), int'(rx_q[i]), i);
      chk("burst_empty_end", int'(empty), 1);

      // ---- simultaneous write and pop at level 3 ----
      u_mode = M_STALL;
      rx_q.delete();
      run(3);
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h31 + i);
         tick();
      end
      wr_en = 1'b0;
      chk("simul_level_pre", int'(level), 3);
      u_mode = M_NORMAL;
      run(3);
      wr_en = 1'b1; wr_data = 8'h55;
      tick();
      wr_en = 1'b0;
      chk("simul_level_hold", int'(level), 3);
      chk("simul_se", int'(send_enable), 1);
      chk("simul_data", int'(send_data), 8'h31);
      drain("simul_drain");
      chk("simul_rx_count", rx_q.size(), 4);
      if (rx_q.size() == 4) begin
         chk("simul_rx0", int'(rx_q[0]), 8'h31);
         chk("simul_rx1", int'(rx_q[1]), 8'h32);
         chk("simul_rx2", int'(rx_q[2]), 8'h33);
         chk("simul_rx3", int'(rx_q[3]), 8'h55);
      end

      // ---- timeout with a silent transmitter ----
      u_mode = M_DEAD;
      run(3);
      wr_en = 1'b1; wr_data = 8'hAA;
      tick();
      wr_en = 1'b0;
      cnt = 0; last_se = -1; err_at = -1; errs = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (send_enable) begin cnt++; last_se = i; end
         if (tx_err) begin errs++; err_at = i; end
      end
      chk("tmo_se_cycles", cnt, ATO);
      chk("tmo_err_pulses", errs, 1);
      chk("tmo_err_after_se", err_at, last_se + 1);
      chk("tmo_level", int'(level), 0);

      // ---- asynchronous reset mid-handshake ----
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
         tick();
      end
      wr_en = 1'b0;
      chk("rstmid_se", int'(send_enable), 1);
      chk("rstmid_level", int'(level), 5);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rstmid_async_se", int'(send_enable), 0);
      chk("rstmid_async_sd", int'(send_data), 0);
      chk("rstmid_async_level", int'(level), 0);
      chk("rstmid_async_empty", int'(empty), 1);
      chk("rstmid_async_full", int'(full), 0);
      chk("rstmid_async_ovf", int'(overflow), 0);
      chk("rstmid_async_err", int'(tx_err), 0);
      run(2);
      rst_n = 1'b1;
      run(3);
      chk("rstmid_after_empty", int'(empty), 1);
      chk("rstmid_after_se", int'(send_enable), 0);

      // ---- randomized traffic against the model ----
      u_mode = M_NORMAL;
      for (int i = 0; i < 2500; i++) begin
         u_mode  = ((i % 500) >= 300 && (i % 500) < 340) ? M_STALL : M_NORMAL;
         u_delay = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, 2));
         u_len   = int'($urandom_range(1, 12));
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_data = 8'($urandom);
         tick();
      end
      u_mode = M_NORMAL; u_delay = 0; u_len = 4;
      drain("random_drain");
      chk("random_empty_end", int'(empty), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte-buffering front end for the 8N1 UART transmitter. It accepts bytes from system logic in the `clk` domain and stores them in a FIFO. It then issues them one at a time to the transmitter through its `send_enable`/`send_data`/`uart_busy` handshake. It sits directly upstream of `uart_tx_8n1` and replaces ad-hoc enable/busy sequencing in the top level. It absorbs bursts and handles the crossing of `uart_busy` from the baud-clock domain.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `ACK_TIMEOUT`, 4096: `clk` cycles to wait for `uart_busy` to rise after `send_enable` before aborting the attempt.
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `wr_en`  input  1  write strobe; one byte per cycle.
- `wr_data`  input  8  byte to enqueue.
- `full`  output  1  FIFO holds DEPTH bytes.
- `empty`  output  1  FIFO holds 0 bytes.
- `level`  output  $clog2(DEPTH)+1  current occupancy.
- `overflow`  output  1  one-cycle pulse when a write is dropped.
- `tx_err`  output  1  one-cycle pulse when an attempt times out.
- `send_enable`  output  1  request to transmitter; registered.
- `send_data`  output  8  byte presented to transmitter; registered, stable while `send_enable`=1.
- `uart_busy`  input  1  transmitter busy flag, asynchronous to `clk`.

## Operation
- Reset values of outputs:
  - `send_enable`=0, `send_data`=0, `level`=0
  - `empty`=1, `full`=0, `overflow`=0, `tx_err`=0
  - FSM=IDLE; pointers and both synchronizer flops cleared.
- `uart_busy` passes through a 2-flop synchronizer (`busy_s`). The FSM uses only `busy_s`.
- FIFO write:
  - When `wr_en`=1 and `full`=0, the byte is stored and the write pointer advances, wrapping modulo DEPTH.
  - When `wr_en`=1 and `full`=1, the byte is dropped and `overflow` pulses. This holds even if a pop occurs in the same cycle, because `full` is evaluated from the registered count.
- FIFO pop happens only on the IDLE→ISSUE transition. It never happens when `empty`=1.
- A simultaneous accepted write and pop leaves `level` unchanged.
- FSM states:
  - IDLE: if `empty`=0 and `busy_s`=0, load the head byte into `send_data`, pop, set `send_enable`=1, and go to ISSUE.
  - ISSUE: hold `send_enable`=1 and `send_data`.
    - If `busy_s`=1, drop `send_enable` and go to DRAIN.
    - If the timeout counter reaches ACK_TIMEOUT-1, drop `send_enable`, pulse `tx_err`, and go to IDLE. The byte is discarded, not retried.
  - DRAIN: wait for `busy_s`=0, then go to IDLE.
- The timeout counter clears on entry to ISSUE and saturates. Its width is $clog2(ACK_TIMEOUT)+1.
- Asserting `rst_n` at any point, including mid-handshake, returns all state to the reset values immediately. Queued bytes are lost. A frame already started in the transmitter is not this block's concern.

## Timing
- Write into an empty FIFO at edge N:
  - `level`=1 and `empty`=0 after edge N.
  - FSM leaves IDLE at edge N+1, so `send_enable`=1 after edge N+1.
- `send_enable` remains high until `busy_s` is seen. That is at least 2 `clk` cycles after `uart_busy` rises, plus the baud-clock delay to sample `send_enable`.
- Between bytes there is at least one IDLE cycle after `busy_s` falls. Back-to-back bytes are therefore never issued while the transmitter reports busy.
- Throughput is bounded by the UART, one byte per frame. The FIFO accepts one write per `clk` cycle.
- `overflow` and `tx_err` are single-cycle pulses, asserted the cycle after the causing edge.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state encoding (IDLE, ISSUE, DRAIN)
  - the 8N1 data width constant (8)
- Sub-module `sync_2ff` (parameterised width, async active-low reset) is the natural reusable piece for `uart_busy`. The FIFO storage and pointers stay inline.

## Test plan
- Single byte: write 0x41 to the idle block.
  - `send_enable` rises 2 cycles later with `send_data`=0x41.
  - It falls within 3 cycles of `uart_busy` rising.
  - A model receiver sees exactly one 0x41 frame.
- Burst: write 0x00..0x0F on 16 consecutive cycles.
  - `full`=1 after the 16th write (`level`=16).
  - The model receiver gets 0x00..0x0F in order, and `empty`=1 at the end.
- Overflow: with the UART stalled busy, write 17 bytes.
  - The 17th is dropped, `overflow` pulses once, and `level` stays 16.
- Simultaneous: write 0x55 in the same cycle as a pop while `level`=3.
  - `level` stays 3 and ordering is preserved.
- Timeout: tie `uart_busy`=0 with ACK_TIMEOUT=8 and write 0xAA.
  - `send_enable` is high for 8 cycles, then `tx_err` pulses.
  - FSM returns to IDLE with `level`=0.
- Reset mid-handshake: drop `rst_n` while in ISSUE with `level`=5.
  - All outputs take their reset values without waiting for a clock edge.
  - After release the block is idle and `empty`=1.
